// File: rtl/led_color_sequencer.sv
// RGB LED colour sequencer: samples a divided step clock on clk_in and walks a
// six-colour palette in static, step, breathing or off modes with 8-bit PWM.
module led_color_sequencer #(
    parameter int ACTIVE_LOW  = 1,
    parameter int BREATH_STEP = 8
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       step_clk,
    input  logic [1:0] mode,
    input  logic       pause,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [2:0] color_idx,
    output logic       color_adv
);

    localparam logic [1:0] MODE_STATIC  = 2'b00;
    localparam logic [1:0] MODE_STEP    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

    localparam logic       OFF_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [8:0] STEP9   = 9'(BREATH_STEP);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic       sync1_p0;
    logic       sync2_p1;
    logic       hist_p2;
    logic [1:0] warm;
    logic       step_pulse;
    logic       step_go;

    logic [1:0] mode_q;
    logic       mode_chg;

    logic [7:0] pwm_cnt;
    logic [7:0] level;
    logic [7:0] level_next;
    dir_t       dir;
    dir_t       dir_next;
    logic [2:0] idx_next;
    logic       adv_next;

    logic [8:0]        sum;
    logic signed [9:0] diff;

    logic [2:0] rgb;
    logic       duty_hit;
    logic       led_r_next;
    logic       led_g_next;
    logic       led_b_next;

    function automatic logic [8:0] level_up(input logic [7:0] lvl);
        return {1'b0, lvl} + STEP9;
    endfunction

    function automatic logic signed [9:0] level_down(input logic [7:0] lvl);
        return $signed({2'b00, lvl}) - $signed({1'b0, STEP9});
    endfunction

    function automatic logic [2:0] palette(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b100;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b010;
            3'd3:    c = 3'b011;
            3'd4:    c = 3'b001;
            3'd5:    c = 3'b101;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] idx_inc(input logic [2:0] idx);
        return (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    // Edge detect is held off until hist carries a real post-reset sample, so a
    // step_clk already high across reset is not mistaken for a fresh edge.
    assign step_pulse = sync2_p1 & ~hist_p2 & (warm == 2'd3);
    assign mode_chg   = (mode != mode_q);
    assign step_go    = step_pulse & ~pause & ~mode_chg;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1_p0  <= 1'b0;
            sync2_p1  <= 1'b0;
            hist_p2   <= 1'b0;
            warm      <= 2'd0;
            mode_q    <= 2'b00;
            pwm_cnt   <= 8'd0;
            level     <= 8'd0;
            dir       <= DIR_UP;
            color_idx <= 3'd0;
            color_adv <= 1'b0;
            led_r     <= OFF_LVL;
            led_g     <= OFF_LVL;
            led_b     <= OFF_LVL;
        end else begin
            sync1_p0  <= step_clk;
            sync2_p1  <= sync1_p0;
            hist_p2   <= sync2_p1;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
            mode_q    <= mode;
            pwm_cnt   <= pwm_cnt + 8'd1;
            level     <= level_next;
            dir       <= dir_next;
            color_idx <= idx_next;
            color_adv <= adv_next;
            led_r     <= led_r_next;
            led_g     <= led_g_next;
            led_b     <= led_b_next;
        end
    end

    // Next-state logic
    always_comb begin
        level_next = level;
        dir_next   = dir;
        idx_next   = color_idx;
        adv_next   = 1'b0;
        sum        = level_up(level);
        diff       = level_down(level);
        if (mode_chg) begin
            level_next = 8'd0;
            dir_next   = DIR_UP;
        end else if (step_go) begin
            case (mode_q)
                MODE_STEP: begin
                    idx_next = idx_inc(color_idx);
                    adv_next = 1'b1;
                end
                MODE_BREATHE: begin
                    if (dir == DIR_UP) begin
                        if (sum >= 9'd255) begin
                            level_next = 8'd255;
                            dir_next   = DIR_DOWN;
                        end else begin
                            level_next = sum[7:0];
                        end
                    end else begin
                        if (diff <= 10'sd0) begin
                            level_next = 8'd0;
                            dir_next   = DIR_UP;
                            idx_next   = idx_inc(color_idx);
                            adv_next   = 1'b1;
                        end else begin
                            level_next = diff[7:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic: PWM compare against the pre-increment counter
    always_comb begin
        rgb      = palette(color_idx);
        duty_hit = 1'b0;
        case (mode_q)
            MODE_STATIC,
            MODE_STEP:    duty_hit = (pwm_cnt < 8'd255);
            MODE_BREATHE: duty_hit = (pwm_cnt < level);
            MODE_OFF:     duty_hit = 1'b0;
            default:      duty_hit = 1'b0;
        endcase
        led_r_next = (rgb[2] & duty_hit) ? ~OFF_LVL : OFF_LVL;
        led_g_next = (rgb[1] & duty_hit) ? ~OFF_LVL : OFF_LVL;
        led_b_next = (rgb[0] & duty_hit) ? ~OFF_LVL : OFF_LVL;
    end

endmodule

// File: tb/tb_led_color_sequencer.sv
// Bench for led_color_sequencer: directed phases plus random traffic, all
// checked cycle by cycle against a behavioural model of the colour rules.
module tb_led_color_sequencer;

    localparam int AL = 1;
    localparam int BS = 64;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_clk = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       pause = 1'b0;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic [2:0] color_idx;
    logic       color_adv;

    led_color_sequencer #(
        .ACTIVE_LOW (AL),
        .BREATH_STEP(BS)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .step_clk (step_clk),
        .mode     (mode),
        .pause    (pause),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b),
        .color_idx(color_idx),
        .color_adv(color_adv)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int adv_seen = 0;

    // Behavioural model state
    int pal[6] = '{4, 6, 2, 3, 1, 5};
    int m_idx = 0;
    int m_level = 0;
    int m_cnt = 0;
    int m_modeq = 0;
    bit m_up = 1'b1;
    bit m_adv = 1'b0;
    bit m_led[3] = '{1'b1, 1'b1, 1'b1};
    bit samp[$];
    bit inactive = (AL != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Applies the colour rules for one clk_in edge using the inputs now present
    task automatic model_edge();
        bit pulse;
        int duty;
        int t;
        if (!rst_n) begin
            m_idx = 0; m_level = 0; m_cnt = 0; m_modeq = 0; m_up = 1'b1; m_adv = 1'b0;
            for (int c = 0; c < 3; c++) m_led[c] = inactive;
            samp.delete();
            return;
        end
        pulse = (samp.size() >= 3) && samp[1] && !samp[2];
        if (m_modeq == 3) duty = 0;
        else if (m_modeq == 2) duty = m_level;
        else duty = 255;
        for (int c = 0; c < 3; c++)
            m_led[c] = (pal[m_idx][2-c] && (m_cnt < duty)) ? !inactive : inactive;
        m_adv = 1'b0;
        if (int'(mode) != m_modeq) begin
            m_level = 0;
            m_up = 1'b1;
        end else if (pulse && !pause) begin
            if (m_modeq == 1) begin
                m_idx = (m_idx + 1) % 6;
                m_adv = 1'b1;
            end else if (m_modeq == 2) begin
                if (m_up) begin
                    t = m_level + BS;
                    if (t >= 255) begin m_level = 255; m_up = 1'b0; end
                    else m_level = t;
                end else begin
                    t = m_level - BS;
                    if (t <= 0) begin
                        m_level = 0; m_up = 1'b1;
                        m_idx = (m_idx + 1) % 6;
                        m_adv = 1'b1;
                    end else m_level = t;
                end
            end
        end
        m_cnt = (m_cnt + 1) % 256;
        m_modeq = int'(mode);
        samp.push_front(step_clk);
        if (samp.size() > 3) void'(samp.pop_back());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
        chk("led_r", led_r, m_led[0]);
        chk("led_g", led_g, m_led[1]);
        chk("led_b", led_b, m_led[2]);
        chk("color_idx", color_idx, m_idx);
        chk("color_adv", color_adv, m_adv);
        if (color_adv === 1'b1) adv_seen++;
    endtask

    task automatic measure(output int r_on, output int g_on, output int b_on);
        r_on = 0; g_on = 0; b_on = 0;
        repeat (256) begin
            tick();
            if (led_r === 1'b0) r_on++;
            if (led_g === 1'b0) g_on++;
            if (led_b === 1'b0) b_on++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_idx[7] = '{1, 2, 3, 4, 5, 0, 1};
        int exp_lvl[8] = '{64, 128, 192, 255, 191, 127, 63, 0};
        int r_on, g_on, b_on;

        // Reset
        do_reset();
        chk("rst_led_r", led_r, 1);
        chk("rst_led_g", led_g, 1);
        chk("rst_led_b", led_b, 1);
        chk("rst_idx", color_idx, 0);
        chk("rst_adv", color_adv, 0);

        // Step mode
        mode = 2'b01;
        repeat (4) tick();
        adv_seen = 0;
        for (int i = 0; i < 7; i++) begin
            step_clk = 1'b1;
            repeat (3) tick();
            chk("step_adv_hi", color_adv, 1);
            chk("step_idx", color_idx, exp_idx[i]);
            tick();
            chk("step_adv_lo", color_adv, 0);
            step_clk = 1'b0;
            repeat (4) tick();
        end
        chk("step_adv_cnt", adv_seen, 7);

        // Breathing
        mode = 2'b00;
        do_reset();
        mode = 2'b10;
        repeat (4) tick();
        adv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step_clk = 1'b1;
            repeat (3) tick();
            step_clk = 1'b0;
            measure(r_on, g_on, b_on);
            chk($sformatf("brth_r_on%0d", i), r_on, exp_lvl[i]);
            chk($sformatf("brth_g_on%0d", i), g_on, 0);
            chk($sformatf("brth_b_on%0d", i), b_on, 0);
        end
        chk("brth_adv_cnt", adv_seen, 1);
        chk("brth_idx", color_idx, 1);

        // Pause
        pause = 1'b1;
        adv_seen = 0;
        repeat (4) begin
            step_clk = 1'b1;
            repeat (4) tick();
            step_clk = 1'b0;
            repeat (4) tick();
        end
        measure(r_on, g_on, b_on);
        chk("pause_r_on", r_on, 0);
        chk("pause_idx", color_idx, 1);
        chk("pause_adv_cnt", adv_seen, 0);
        pause = 1'b0;
        step_clk = 1'b1;
        repeat (3) tick();
        step_clk = 1'b0;
        measure(r_on, g_on, b_on);
        chk("unpause_r_on", r_on, 64);
        chk("unpause_g_on", g_on, 64);

        // Mode change coinciding with a step pulse
        step_clk = 1'b1;
        repeat (2) tick();
        mode = 2'b01;
        tick();
        chk("mchg_adv", color_adv, 0);
        chk("mchg_idx", color_idx, 1);
        step_clk = 1'b0;
        repeat (6) tick();
        mode = 2'b11;
        repeat (2) tick();
        chk("off_led_r", led_r, 1);
        chk("off_led_g", led_g, 1);
        chk("off_led_b", led_b, 1);
        repeat (10) tick();

        // Reset while step_clk is held high
        mode = 2'b01;
        repeat (4) tick();
        step_clk = 1'b1;
        repeat (5) tick();
        chk("mid_pre_idx", color_idx, 2);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_idx", color_idx, 0);
        chk("mid_rst_adv", color_adv, 0);
        chk("mid_rst_led_r", led_r, 1);
        rst_n = 1'b1;
        adv_seen = 0;
        repeat (12) tick();
        chk("mid_no_adv", adv_seen, 0);
        chk("mid_idx_hold", color_idx, 0);
        step_clk = 1'b0;
        repeat (4) tick();
        step_clk = 1'b1;
        repeat (3) tick();
        chk("mid_fresh_adv", color_adv, 1);
        chk("mid_fresh_idx", color_idx, 1);
        step_clk = 1'b0;
        repeat (4) tick();

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 9999));
            if (r % 7 == 0) step_clk = ~step_clk;
            if (r % 89 == 0) mode = 2'($urandom_range(0, 3));
            if (r % 53 == 0) pause = ~pause;
            rst_n = (r % 397 == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
